// File: rtl/turfio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : turfio_pkg
// Description : Shared bank-sequencer state codes, local register offsets and
//               a saturating counter helper for the TURFIO bank controller.
// Revision    : 1.0 - initial release
// ============================================================================
package turfio_pkg;

    // Bank sequencer states; the numeric codes are visible in STATUS.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MMCM_RST  = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_DLY_RST   = 3'd3,
        ST_WAIT_RDY  = 3'd4,
        ST_BANK_RST  = 3'd5,
        ST_READY     = 3'd6,
        ST_FAULT     = 3'd7
    } bank_state_e;

    // Local register word offsets (wb_adr_i[3:2]).
    localparam logic [1:0] c_reg_ctrl     = 2'd0;
    localparam logic [1:0] c_reg_status   = 2'd1;
    localparam logic [1:0] c_reg_faultcnt = 2'd2;

    localparam logic [7:0] c_fault_cnt_max = 8'hFF;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == c_fault_cnt_max) ? v : v + 8'd1;
    endfunction

endpackage : turfio_pkg
`default_nettype wire

// File: rtl/turfio_bank_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : turfio_bank_seq
// Description : Per-bank reset sequencer: MMCM reset, wait for lock,
//               IDELAYCTRL reset, wait for ready, bank reset, then READY.
//               Lock loss in READY moves to FAULT and bumps a fault counter.
// Revision    : 1.0 - initial release
// ============================================================================
module turfio_bank_seq
    import turfio_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       clr_fault_i,
    input  logic       mmcm_locked_i,
    input  logic       idelayctrl_rdy_i,
    output logic       mmcm_rst_o,
    output logic       idelayctrl_rst_o,
    output logic       bank_rst_o,
    output logic       ready_o,
    output logic [2:0] state_o,
    output logic [7:0] fault_cnt_o
);

    // One counter serves both the reset-hold and the timeout windows.
    localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] c_rst_last = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(LOCK_TIMEOUT - 1);

    logic lock_meta_q, lock_sync_q;
    logic rdy_meta_q, rdy_sync_q;

    bank_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       fault_cnt_q, fault_cnt_d;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic             dly_rst_q, dly_rst_d;
    logic             bank_rst_q, bank_rst_d;
    logic             ready_q, ready_d;

    // Two-flop synchronizers for the asynchronous status inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            rdy_meta_q  <= 1'b0;
            rdy_sync_q  <= 1'b0;
        end else begin
            lock_meta_q <= mmcm_locked_i;
            lock_sync_q <= lock_meta_q;
            rdy_meta_q  <= idelayctrl_rdy_i;
            rdy_sync_q  <= rdy_meta_q;
        end
    end

    // Next-state, counter and output decode; outputs follow the next state so
    // they are registered yet aligned with the state they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fault_cnt_d = fault_cnt_q;
        if (start_i) begin
            state_d = ST_MMCM_RST;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_MMCM_RST, ST_DLY_RST, ST_BANK_RST: begin
                    if (cnt_q == c_rst_last) begin
                        cnt_d = '0;
                        case (state_q)
                            ST_MMCM_RST: state_d = ST_WAIT_LOCK;
                            ST_DLY_RST:  state_d = ST_WAIT_RDY;
                            default:     state_d = ST_READY;
                        endcase
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK, ST_WAIT_RDY: begin
                    if ((state_q == ST_WAIT_LOCK) ? lock_sync_q : rdy_sync_q) begin
                        state_d = (state_q == ST_WAIT_LOCK) ? ST_DLY_RST : ST_BANK_RST;
                        cnt_d   = '0;
                    end else if (cnt_q == c_tmo_last) begin
                        state_d = ST_FAULT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (!lock_sync_q) begin
                        state_d     = ST_FAULT;
                        fault_cnt_d = sat_inc8(fault_cnt_q);
                    end
                end
                default: ;
            endcase
        end
        if (clr_fault_i) begin
            fault_cnt_d = '0;
        end
        mmcm_rst_d = (state_d == ST_MMCM_RST);
        dly_rst_d  = (state_d == ST_DLY_RST);
        bank_rst_d = (state_d == ST_BANK_RST);
        ready_d    = (state_d == ST_READY);
    end

    // Sequencer state, counters and registered outputs; async reset drops
    // every reset output immediately and parks the bank in IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fault_cnt_q <= '0;
            mmcm_rst_q  <= 1'b0;
            dly_rst_q   <= 1'b0;
            bank_rst_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fault_cnt_q <= fault_cnt_d;
            mmcm_rst_q  <= mmcm_rst_d;
            dly_rst_q   <= dly_rst_d;
            bank_rst_q  <= bank_rst_d;
            ready_q     <= ready_d;
        end
    end

    assign mmcm_rst_o       = mmcm_rst_q;
    assign idelayctrl_rst_o = dly_rst_q;
    assign bank_rst_o       = bank_rst_q;
    assign ready_o          = ready_q;
    assign state_o          = state_q;
    assign fault_cnt_o      = fault_cnt_q;

endmodule : turfio_bank_seq
`default_nettype wire

// File: rtl/turfio_bank_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : turfio_bank_ctrl
// Description : WISHBONE target that fans out to NUM_IF TURFIO interfaces
//               (upper half of the address space) and hosts the clock-bank
//               reset sequencer registers (lower half).
// Revision    : 1.0 - initial release
// ============================================================================
module turfio_bank_ctrl
    import turfio_pkg::*;
#(
    parameter  int NUM_IF       = 4,
    parameter  int NUM_BANK     = 2,
    parameter  int RST_CYCLES   = 16,
    parameter  int LOCK_TIMEOUT = 65535,
    localparam int IF_SEL_BITS  = $clog2(NUM_IF),
    localparam int IF_ADR_BITS  = 14 - IF_SEL_BITS
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wb_cyc_i,
    input  logic                          wb_stb_i,
    input  logic                          wb_we_i,
    input  logic [14:0]                   wb_adr_i,
    input  logic [3:0]                    wb_sel_i,
    input  logic [31:0]                   wb_dat_i,
    output logic [31:0]                   wb_dat_o,
    output logic                          wb_ack_o,
    output logic                          wb_err_o,
    output logic                          wb_rty_o,
    output logic [NUM_IF-1:0]             wbm_cyc_o,
    output logic [NUM_IF-1:0]             wbm_stb_o,
    output logic [NUM_IF-1:0]             wbm_we_o,
    output logic [NUM_IF*IF_ADR_BITS-1:0] wbm_adr_o,
    output logic [NUM_IF*4-1:0]           wbm_sel_o,
    output logic [NUM_IF*32-1:0]          wbm_dat_o,
    input  logic [NUM_IF*32-1:0]          wbm_dat_i,
    input  logic [NUM_IF-1:0]             wbm_ack_i,
    input  logic [NUM_IF-1:0]             wbm_err_i,
    input  logic [NUM_IF-1:0]             wbm_rty_i,
    output logic [NUM_BANK-1:0]           mmcm_rst_o,
    output logic [NUM_BANK-1:0]           idelayctrl_rst_o,
    output logic [NUM_BANK-1:0]           bank_rst_o,
    input  logic [NUM_BANK-1:0]           mmcm_locked_i,
    input  logic [NUM_BANK-1:0]           idelayctrl_rdy_i,
    output logic [NUM_BANK-1:0]           bank_ready_o
);

    logic                   w_remote;
    logic [IF_SEL_BITS-1:0] w_if_sel;
    logic                   w_local_new;
    logic [1:0]             w_reg_sel;
    logic [31:0]            w_status;
    logic [31:0]            w_faultcnt;

    logic                ack_q, ack_d;
    logic [NUM_BANK-1:0] start_q, start_d;
    logic                clr_fault_q, clr_fault_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [2:0] bank_state [NUM_BANK];
    logic [7:0] bank_fault [NUM_BANK];

    assign w_remote  = wb_adr_i[14];
    assign w_if_sel  = wb_adr_i[13 -: IF_SEL_BITS];
    assign w_reg_sel = wb_adr_i[3:2];
    // First cycle of a local access; suppressed while the ack is out so each
    // access cycle acts exactly once.
    assign w_local_new = wb_cyc_i & wb_stb_i & ~w_remote & ~ack_q;

    // Remote fan-out: cyc is decoded per interface, the rest is broadcast.
    for (genvar n = 0; n < NUM_IF; n++) begin : g_if
        assign wbm_cyc_o[n] = wb_cyc_i & w_remote & (w_if_sel == IF_SEL_BITS'(n));
        assign wbm_stb_o[n] = wb_stb_i;
        assign wbm_we_o[n]  = wb_we_i;
        assign wbm_sel_o[4*n +: 4]   = wb_sel_i;
        assign wbm_dat_o[32*n +: 32] = wb_dat_i;
        assign wbm_adr_o[IF_ADR_BITS*n +: IF_ADR_BITS] = wb_adr_i[IF_ADR_BITS-1:0];
    end

    // One sequencer per clock bank.
    for (genvar k = 0; k < NUM_BANK; k++) begin : g_bank
        turfio_bank_seq #(
            .RST_CYCLES   (RST_CYCLES),
            .LOCK_TIMEOUT (LOCK_TIMEOUT)
        ) u_seq (
            .clk_i            (clk_i),
            .rst_i            (rst_i),
            .start_i          (start_q[k]),
            .clr_fault_i      (clr_fault_q),
            .mmcm_locked_i    (mmcm_locked_i[k]),
            .idelayctrl_rdy_i (idelayctrl_rdy_i[k]),
            .mmcm_rst_o       (mmcm_rst_o[k]),
            .idelayctrl_rst_o (idelayctrl_rst_o[k]),
            .bank_rst_o       (bank_rst_o[k]),
            .ready_o          (bank_ready_o[k]),
            .state_o          (bank_state[k]),
            .fault_cnt_o      (bank_fault[k])
        );
    end

    // Pack per-bank status nibbles and fault-counter bytes into 32-bit words.
    always_comb begin
        w_status   = '0;
        w_faultcnt = '0;
        for (int k = 0; k < NUM_BANK; k++) begin
            if (k < 8) w_status[4*k +: 4]   = {bank_ready_o[k], bank_state[k]};
            if (k < 4) w_faultcnt[8*k +: 8] = bank_fault[k];
        end
    end

    // Local register decode: start pulse, counter clear, read data and ack.
    always_comb begin
        ack_d       = w_local_new;
        start_d     = '0;
        clr_fault_d = 1'b0;
        if (w_local_new && wb_we_i) begin
            if (w_reg_sel == c_reg_ctrl && wb_sel_i[0]) start_d = wb_dat_i[NUM_BANK-1:0];
            if (w_reg_sel == c_reg_faultcnt)            clr_fault_d = 1'b1;
        end
        case (w_reg_sel)
            c_reg_status:   rdata_d = w_status;
            c_reg_faultcnt: rdata_d = w_faultcnt;
            default:        rdata_d = '0;
        endcase
    end

    // Registered local response and one-cycle control pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q       <= 1'b0;
            start_q     <= '0;
            clr_fault_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            ack_q       <= ack_d;
            start_q     <= start_d;
            clr_fault_q <= clr_fault_d;
            rdata_q     <= rdata_d;
        end
    end

    // Response mux: remote responses pass straight through, local ones are
    // the registered ack/data gated by cyc.
    always_comb begin
        if (w_remote) begin
            wb_dat_o = wbm_dat_i[32*int'(w_if_sel) +: 32];
            wb_ack_o = wbm_ack_i[w_if_sel];
            wb_err_o = wbm_err_i[w_if_sel];
            wb_rty_o = wbm_rty_i[w_if_sel];
        end else begin
            wb_dat_o = rdata_q;
            wb_ack_o = ack_q & wb_cyc_i;
            wb_err_o = 1'b0;
            wb_rty_o = 1'b0;
        end
    end

endmodule : turfio_bank_ctrl
`default_nettype wire

// File: tb/tb_turfio_bank_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_turfio_bank_ctrl
// Description : Directed self-checking bench for turfio_bank_ctrl
//               (NUM_IF=4, NUM_BANK=2, RST_CYCLES=16, LOCK_TIMEOUT=1000).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turfio_bank_ctrl;

    localparam int NUM_IF = 4;
    localparam int NUM_BANK = 2;
    localparam int ADR_W = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [14:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_w, wb_dat_r;
    logic        wb_ack, wb_err, wb_rty;
    logic [NUM_IF-1:0]       wbm_cyc, wbm_stb, wbm_we;
    logic [NUM_IF*ADR_W-1:0] wbm_adr;
    logic [NUM_IF*4-1:0]     wbm_sel;
    logic [NUM_IF*32-1:0]    wbm_dat_o, wbm_dat_i;
    logic [NUM_IF-1:0]       wbm_ack, wbm_err, wbm_rty;
    logic [NUM_BANK-1:0]     mmcm_rst, dly_rst, bank_rst, locked, rdy, bank_ready;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] last_errrty;

    turfio_bank_ctrl #(
        .NUM_IF(NUM_IF), .NUM_BANK(NUM_BANK), .RST_CYCLES(16), .LOCK_TIMEOUT(1000)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_adr_i(wb_adr),
        .wb_sel_i(wb_sel), .wb_dat_i(wb_dat_w),
        .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_rty_o(wb_rty),
        .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we), .wbm_adr_o(wbm_adr),
        .wbm_sel_o(wbm_sel), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_rty_i(wbm_rty),
        .mmcm_rst_o(mmcm_rst), .idelayctrl_rst_o(dly_rst), .bank_rst_o(bank_rst),
        .mmcm_locked_i(locked), .idelayctrl_rdy_i(rdy), .bank_ready_o(bank_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Single local WISHBONE access; waits (bounded) for the ack.
    task automatic wb_xfer(input logic we_in, input logic [14:0] adr_in,
                           input logic [31:0] dat_in, output logic [31:0] rd);
        int t;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we_in;
        wb_adr = adr_in; wb_dat_w = dat_in; wb_sel = 4'hF;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wb_ack && t < 20);
        if (!wb_ack) chk("wb_ack_timeout", 32'(wb_ack), 32'd1);
        rd = wb_dat_r;
        last_errrty = {wb_err, wb_rty};
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    function automatic logic sig_of(input int which, input int b);
        case (which)
            0:       return mmcm_rst[b];
            1:       return dly_rst[b];
            2:       return bank_rst[b];
            default: return bank_ready[b];
        endcase
    endfunction

    // Wait for a reset output to rise, then count how many cycles it stays high.
    task automatic measure_pulse(input string tag, input int which, input int b, input int exp_w);
        int t;
        int w;
        t = 0;
        while (!sig_of(which, b) && t < 1500) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_rise"}, 32'(sig_of(which, b)), 32'd1);
        w = 0;
        while (sig_of(which, b) && w < 200) begin
            w++;
            @(negedge clk);
        end
        chk({tag, "_width"}, 32'(w), 32'(exp_w));
    endtask

    task automatic lock_glitch();
        @(negedge clk);
        locked[0] = 1'b0;
        repeat (3) @(negedge clk);
        locked[0] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        int t;
        int n_tmo;

        rst = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_adr = '0; wb_sel = '0; wb_dat_w = '0;
        wbm_ack = '0; wbm_err = '0; wbm_rty = '0;
        for (int n = 0; n < NUM_IF; n++) wbm_dat_i[32*n +: 32] = 32'h1111_0000 + 32'(n);
        wbm_dat_i[32 +: 32] = 32'hDEAD_BEEF;
        locked = 2'b00;
        rdy    = 2'b11;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({mmcm_rst, dly_rst, bank_rst, bank_ready}), 32'd0);
        rst = 1'b0;
        wb_xfer(1'b0, 15'h0004, 32'd0, rd);
        chk("rst_status", rd, 32'd0);
        chk("local_err_rty", 32'(last_errrty), 32'd0);
        wb_xfer(1'b0, 15'h0008, 32'd0, rd);
        chk("rst_faultcnt", rd, 32'd0);

        // Remote access to interface 1
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 15'h5004; wb_sel = 4'hF;
        #1;
        chk("rem_cyc", 32'(wbm_cyc), 32'h2);
        chk("rem_stb_bcast", 32'(wbm_stb), 32'hF);
        chk("rem_adr1", 32'(wbm_adr[ADR_W +: ADR_W]), 32'h004);
        chk("rem_ack_pre", 32'(wb_ack), 32'd0);
        @(negedge clk);
        wbm_ack[1] = 1'b1;
        #1;
        chk("rem_ack", 32'(wb_ack), 32'd1);
        chk("rem_dat", wb_dat_r, 32'hDEAD_BEEF);
        wbm_ack = '0; wbm_err[1] = 1'b1;
        #1;
        chk("rem_err", 32'(wb_err), 32'd1);
        wbm_err = '0; wbm_ack[2] = 1'b1;
        #1;
        chk("rem_other_ack", 32'(wb_ack), 32'd0);
        wbm_ack = '0;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        #1;
        chk("rem_idle", 32'(wbm_cyc), 32'd0);

        // Lock timeout on bank 0, bank 1 untouched
        wb_xfer(1'b1, 15'h0000, 32'h1, rd);
        repeat (1100) @(negedge clk);
        wb_xfer(1'b0, 15'h0004, 32'd0, rd);
        chk("tmo_state", 32'(rd[2:0]), 32'd7);
        chk("tmo_ready_bit", 32'(rd[3]), 32'd0);
        chk("tmo_bank1", 32'(rd[7:4]), 32'd0);
        chk("tmo_ready_o", 32'(bank_ready), 32'd0);
        chk("tmo_bank1_rsts", 32'({mmcm_rst[1], dly_rst[1], bank_rst[1]}), 32'd0);
        wb_xfer(1'b0, 15'h000C, 32'd0, rd);
        chk("unmapped_rd", rd, 32'd0);
        wb_xfer(1'b0, 15'h0000, 32'd0, rd);
        chk("ctrl_rd", rd, 32'd0);
        wb_xfer(1'b0, 15'h0008, 32'd0, rd);
        chk("tmo_faultcnt", rd, 32'd0);

        // Full sequence on bank 0, lock arrives 100 cycles after MMCM reset
        wb_xfer(1'b1, 15'h0000, 32'h1, rd);
        measure_pulse("mmcm0", 0, 0, 16);
        repeat (100) @(negedge clk);
        locked[0] = 1'b1;
        measure_pulse("dly0", 1, 0, 16);
        measure_pulse("bank0", 2, 0, 16);
        chk("ready_o", 32'(bank_ready), 32'h1);
        wb_xfer(1'b0, 15'h0004, 32'd0, rd);
        chk("seq_status", 32'(rd[7:0]), 32'h0E);

        // Lock glitch in READY
        lock_glitch();
        wb_xfer(1'b0, 15'h0004, 32'd0, rd);
        chk("glitch_state", 32'(rd[3:0]), 32'h7);
        wb_xfer(1'b0, 15'h0008, 32'd0, rd);
        chk("faultcnt_1", rd, 32'h01);

        // Saturation of the fault counter
        n_tmo = 0;
        for (int i = 2; i <= 300; i++) begin
            wb_xfer(1'b1, 15'h0000, 32'h1, rd);
            t = 0;
            while (!bank_ready[0] && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!bank_ready[0]) n_tmo++;
            lock_glitch();
            if (i == 254) begin
                wb_xfer(1'b0, 15'h0008, 32'd0, rd);
                chk("faultcnt_254", rd, 32'hFE);
            end
            if (i == 255) begin
                wb_xfer(1'b0, 15'h0008, 32'd0, rd);
                chk("faultcnt_255", rd, 32'hFF);
            end
        end
        chk("loop_ready_tmo", 32'(n_tmo), 32'd0);
        wb_xfer(1'b0, 15'h0008, 32'd0, rd);
        chk("faultcnt_300", rd, 32'hFF);
        wb_xfer(1'b1, 15'h0008, 32'h1234_5678, rd);
        wb_xfer(1'b0, 15'h0008, 32'd0, rd);
        chk("faultcnt_clear", rd, 32'h00);

        // Restart both banks while bank 0 waits for IDELAYCTRL ready
        rdy[0] = 1'b0;
        wb_xfer(1'b1, 15'h0000, 32'h1, rd);
        measure_pulse("dly0_b", 1, 0, 16);
        repeat (5) @(negedge clk);
        wb_xfer(1'b0, 15'h0004, 32'd0, rd);
        chk("wait_rdy_state", 32'(rd[2:0]), 32'd4);
        wb_xfer(1'b1, 15'h0000, 32'h3, rd);
        t = 0;
        while (mmcm_rst == 2'b00 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("both_restart", 32'(mmcm_rst), 32'h3);
        rdy[0] = 1'b1;

        // Async reset during DLY_RST
        t = 0;
        while (!dly_rst[0] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("dly_before_rst", 32'(dly_rst[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_drop", 32'({mmcm_rst, dly_rst, bank_rst, bank_ready}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("post_rst_idle", 32'({mmcm_rst, dly_rst, bank_rst, bank_ready}), 32'd0);
        wb_xfer(1'b0, 15'h0004, 32'd0, rd);
        chk("post_rst_status", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_turfio_bank_ctrl
`default_nettype wire
